// File: rtl/blc_bayer.sv
// rtl/blc_bayer.sv - Bayer black-level correction, 2-stage pipeline, per-channel clamped offset.
// Optional optical-black level measurement is built when BLC_OB_MEAS_EN is defined.
module blc_bayer #(
    parameter int DATA_W   = 24,
    parameter int OFS_W    = 12,
    parameter int H_DISP   = 720,
    parameter int BAYER    = 0,
    parameter int OB_ROWS  = 2,
    parameter int OB_SHIFT = 6
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 blc_en,
    input  logic                 auto_en,
    input  logic [4*OFS_W-1:0]   ofs_cfg,
    input  logic                 in_vsync,
    input  logic                 in_hsync,
    input  logic                 in_de,
    input  logic [DATA_W-1:0]    pixel_data_in,
    output logic                 out_vsync,
    output logic                 out_hsync,
    output logic                 out_de,
    output logic [DATA_W-1:0]    pixel_data_out,
    output logic [4*OFS_W-1:0]   ob_level,
    output logic                 ob_valid
);
    localparam int LC_W = (OB_ROWS > 0) ? $clog2(OB_ROWS + 1) : 1;
    localparam logic [LC_W-1:0] LC_MAX = LC_W'(OB_ROWS);
    localparam logic [1:0] PHASE = 2'(BAYER);

    logic               vs_q, hs_q, de_q;
    logic               armed;
    logic               col_par, row_par;
    logic [LC_W-1:0]    line_cnt;
    logic [4*OFS_W-1:0] sh_ofs;
    logic               vs_rise, hs_rise, de_fall, pass;
    logic [1:0]         ch;

    assign vs_rise = in_vsync & ~vs_q;
    assign hs_rise = in_hsync & ~hs_q;
    assign de_fall = de_q & ~in_de;
    assign pass    = armed | vs_rise;
    assign ch      = {row_par, col_par} ^ PHASE;

    // Stream stays blanked after reset until a frame start re-establishes phase.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vs_q     <= 1'b0;
            hs_q     <= 1'b0;
            de_q     <= 1'b0;
            armed    <= 1'b0;
            col_par  <= 1'b0;
            row_par  <= 1'b0;
            line_cnt <= '0;
            sh_ofs   <= '0;
        end else begin
            vs_q <= in_vsync;
            hs_q <= in_hsync;
            de_q <= in_de;
            if (vs_rise) begin
                armed    <= 1'b1;
                line_cnt <= '0;
                row_par  <= 1'b0;
                sh_ofs   <= ofs_cfg;
            end else if (de_fall) begin
                row_par <= ~row_par;
                if (line_cnt != LC_MAX)
                    line_cnt <= line_cnt + 1'b1;
            end
            if (hs_rise)
                col_par <= 1'b0;
            else if (in_de)
                col_par <= ~col_par;
        end
    end

    logic              s1_vs, s1_hs, s1_de, s1_en;
    logic [1:0]        s1_ch;
    logic [DATA_W-1:0] s1_pix;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_vs  <= 1'b0;
            s1_hs  <= 1'b0;
            s1_de  <= 1'b0;
            s1_en  <= 1'b0;
            s1_ch  <= 2'd0;
            s1_pix <= '0;
        end else begin
            s1_vs  <= in_vsync & pass;
            s1_hs  <= in_hsync & pass;
            s1_de  <= in_de & pass;
            s1_en  <= blc_en;
            s1_ch  <= ch;
            s1_pix <= pass ? pixel_data_in : '0;
        end
    end

`ifdef BLC_OB_MEAS_EN
    localparam int NS    = 1 << OB_SHIFT;
    localparam int CNT_W = OB_SHIFT + 1;
    localparam int ACC_W = OFS_W + OB_SHIFT;

    logic [ACC_W-1:0] acc [4];
    logic [CNT_W-1:0] cnt [4];
    logic             meas_ok, sh_auto, all_full;

    assign all_full = (cnt[0] == CNT_W'(NS)) && (cnt[1] == CNT_W'(NS)) &&
                      (cnt[2] == CNT_W'(NS)) && (cnt[3] == CNT_W'(NS));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 4; i++) begin
                acc[i] <= '0;
                cnt[i] <= '0;
            end
            ob_level <= '0;
            ob_valid <= 1'b0;
            meas_ok  <= 1'b0;
            sh_auto  <= 1'b0;
        end else begin
            ob_valid <= 1'b0;
            if (vs_rise) begin
                sh_auto <= auto_en;
                if (all_full) begin
                    for (int i = 0; i < 4; i++)
                        ob_level[i*OFS_W +: OFS_W] <= OFS_W'(acc[i] >> OB_SHIFT);
                    ob_valid <= 1'b1;
                    meas_ok  <= 1'b1;
                end
                for (int i = 0; i < 4; i++) begin
                    acc[i] <= '0;
                    cnt[i] <= '0;
                end
            end else if (armed && in_de && line_cnt < LC_MAX && cnt[ch] != CNT_W'(NS)) begin
                acc[ch] <= acc[ch] + ACC_W'(pixel_data_in[OFS_W-1:0]);
                cnt[ch] <= cnt[ch] + 1'b1;
            end
        end
    end
`else
    logic unused_auto;
    assign unused_auto = auto_en;
    assign ob_level    = '0;
    assign ob_valid    = 1'b0;
`endif

    logic [OFS_W-1:0]  ofs_sel;
    logic [DATA_W-1:0] ofs_ext;

    always_comb begin
        ofs_sel = sh_ofs[s1_ch*OFS_W +: OFS_W];
`ifdef BLC_OB_MEAS_EN
        if (sh_auto && meas_ok)
            ofs_sel = ob_level[s1_ch*OFS_W +: OFS_W];
`endif
    end

    assign ofs_ext = {{(DATA_W-OFS_W){1'b0}}, ofs_sel};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_vsync      <= 1'b0;
            out_hsync      <= 1'b0;
            out_de         <= 1'b0;
            pixel_data_out <= '0;
        end else begin
            out_vsync <= s1_vs;
            out_hsync <= s1_hs;
            out_de    <= s1_de;
            if (!s1_en)
                pixel_data_out <= s1_pix;
            else if (s1_pix > ofs_ext)
                pixel_data_out <= s1_pix - ofs_ext;
            else
                pixel_data_out <= '0;
        end
    end
endmodule

// File: tb/tb_blc_bayer.sv
// tb/tb_blc_bayer.sv - directed vector bench for blc_bayer (OB checks when BLC_OB_MEAS_EN is defined).
module tb_blc_bayer;
    logic        clk = 1'b0;
    logic        rstn;
    logic        blc_en, auto_en;
    logic [47:0] ofs_cfg;
    logic        in_vsync, in_hsync, in_de;
    logic [23:0] pixel_data_in;
    logic        out_vsync, out_hsync, out_de;
    logic [23:0] pixel_data_out;
    logic [47:0] ob_level;
    logic        ob_valid;

    blc_bayer dut (
        .clk(clk), .rstn(rstn), .blc_en(blc_en), .auto_en(auto_en), .ofs_cfg(ofs_cfg),
        .in_vsync(in_vsync), .in_hsync(in_hsync), .in_de(in_de), .pixel_data_in(pixel_data_in),
        .out_vsync(out_vsync), .out_hsync(out_hsync), .out_de(out_de),
        .pixel_data_out(pixel_data_out), .ob_level(ob_level), .ob_valid(ob_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic [47:0] ofs;
        logic [95:0] pix;
        logic [95:0] exp;
    } vec_t;

    int          compared = 0;
    int          failed   = 0;
    int          nvalid   = 0;
    logic        chk_sync = 1'b0;
    logic [2:0]  d1, d2;
    logic [23:0] outq[$];

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        compared++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            d1 <= 3'b0;
            d2 <= 3'b0;
        end else begin
            d1 <= {in_vsync, in_hsync, in_de};
            d2 <= d1;
        end
    end

    always @(negedge clk) begin
        if (out_de) outq.push_back(pixel_data_out);
        if (ob_valid) nvalid++;
        if (chk_sync) check("sync_delay", {93'b0, out_vsync, out_hsync, out_de}, {93'b0, d2});
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Pixel value at (r,c) picked by CFA channel {r[0],c[0]} (RGGB phase).
    task automatic drive_frame(input int rows, input int cols, input logic [95:0] pix,
                               input int chg_row, input logic [47:0] chg_ofs);
        logic [1:0] idx;
        in_vsync = 1'b1; cyc(2);
        in_vsync = 1'b0; cyc(2);
        for (int r = 0; r < rows; r++) begin
            if (r == chg_row) ofs_cfg = chg_ofs;
            in_hsync = 1'b1; cyc(1);
            in_hsync = 1'b0; cyc(1);
            for (int c = 0; c < cols; c++) begin
                idx = {r[0], c[0]};
                in_de = 1'b1;
                pixel_data_in = pix[idx*24 +: 24];
                cyc(1);
            end
            in_de = 1'b0;
            pixel_data_in = 24'h0;
            cyc(3);
        end
        cyc(2);
    endtask

    task automatic check_q(input string name, input int k, input logic [23:0] exp);
        check(name, (k < outq.size()) ? {72'b0, outq[k]} : {96{1'bx}}, {72'b0, exp});
    endtask

    vec_t vecs[4];
    logic [95:0] all100;
    logic [47:0] v_ofs;
    int          v0;

    initial begin
        vecs[0].en = 1'b1; vecs[0].ofs = {12'd40, 12'd30, 12'd20, 12'd10};
        vecs[0].pix = {24'd100, 24'd100, 24'd100, 24'd100};
        vecs[0].exp = {24'd60, 24'd70, 24'd80, 24'd90};
        vecs[1].en = 1'b1; vecs[1].ofs = {12'd10, 12'd10, 12'd10, 12'd10};
        vecs[1].pix = {24'd0, 24'd11, 24'd10, 24'd5};
        vecs[1].exp = {24'd0, 24'd1, 24'd0, 24'd0};
        vecs[2].en = 1'b0; vecs[2].ofs = {12'd40, 12'd30, 12'd20, 12'd10};
        vecs[2].pix = {24'h123456, 24'h123456, 24'h123456, 24'h123456};
        vecs[2].exp = {24'h123456, 24'h123456, 24'h123456, 24'h123456};
        vecs[3].en = 1'b1; vecs[3].ofs = {12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF};
        vecs[3].pix = {24'h001001, 24'h000FFF, 24'h001000, 24'hFFFFFF};
        vecs[3].exp = {24'h000002, 24'h000000, 24'h000001, 24'hFFF000};
        all100 = {24'd100, 24'd100, 24'd100, 24'd100};

        rstn = 1'b0; blc_en = 1'b1; auto_en = 1'b0; ofs_cfg = 48'h0;
        in_vsync = 1'b0; in_hsync = 1'b0; in_de = 1'b0; pixel_data_in = 24'h0;
        cyc(3);
        check("reset_syncs", {93'b0, out_vsync, out_hsync, out_de}, 96'h0);
        check("reset_pixel", {72'b0, pixel_data_out}, 96'h0);
        check("reset_ob", {47'b0, ob_valid, ob_level}, 96'h0);
        rstn = 1'b1;
        cyc(2);
        chk_sync = 1'b1;

        for (int i = 0; i < 4; i++) begin
            blc_en = vecs[i].en;
            ofs_cfg = vecs[i].ofs;
            outq.delete();
            drive_frame(2, 2, vecs[i].pix, -1, 48'h0);
            check($sformatf("vec%0d_count", i), outq.size(), 4);
            for (int k = 0; k < 4; k++)
                check_q($sformatf("vec%0d_px%0d", i, k), k, vecs[i].exp[k*24 +: 24]);
        end

        // Mid-frame offset change must wait for the next frame start.
        blc_en = 1'b1;
        ofs_cfg = {12'd0, 12'd0, 12'd0, 12'd10};
        outq.delete();
        drive_frame(4, 2, all100, 2, {12'd0, 12'd0, 12'd0, 12'd50});
        check_q("shadow_row0_r", 0, 24'd90);
        check_q("shadow_row2_r", 4, 24'd90);
        outq.delete();
        drive_frame(2, 2, all100, -1, 48'h0);
        check_q("shadow_next_r", 0, 24'd50);

        // Reset in the middle of an active line.
        ofs_cfg = {12'd40, 12'd30, 12'd20, 12'd10};
        chk_sync = 1'b0;
        in_vsync = 1'b1; cyc(2);
        in_vsync = 1'b0; cyc(2);
        in_hsync = 1'b1; cyc(1);
        in_hsync = 1'b0; cyc(1);
        in_de = 1'b1; pixel_data_in = 24'd100;
        cyc(3);
        check("pre_reset_de", {95'b0, out_de}, 96'h1);
        rstn = 1'b0;
        #1;
        check("midreset_syncs", {93'b0, out_vsync, out_hsync, out_de}, 96'h0);
        check("midreset_pixel", {72'b0, pixel_data_out}, 96'h0);
        cyc(1);
        rstn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc(1);
            check($sformatf("hold_de%0d", k), {95'b0, out_de}, 96'h0);
        end
        in_de = 1'b0; pixel_data_in = 24'h0;
        cyc(3);
        check("hold_pixel", {72'b0, pixel_data_out}, 96'h0);
        chk_sync = 1'b1;
        outq.delete();
        drive_frame(2, 2, all100, -1, 48'h0);
        check("resume_count", outq.size(), 4);
        for (int k = 0; k < 4; k++)
            check_q($sformatf("resume_px%0d", k), k, 24'd90 - 24'(k * 10));

`ifdef BLC_OB_MEAS_EN
        check("ob_none_before", nvalid, 0);
        auto_en = 1'b0;
        drive_frame(2, 128, {24'd67, 24'd66, 24'd65, 24'd64}, -1, 48'h0);
        v0 = nvalid;
        auto_en = 1'b1;
        outq.delete();
        drive_frame(2, 2, all100, -1, 48'h0);
        check("ob_pulse_once", nvalid - v0, 1);
        check("ob_level", {48'b0, ob_level}, {48'b0, 12'd67, 12'd66, 12'd65, 12'd64});
        check_q("auto_r", 0, 24'd36);
        check_q("auto_gr", 1, 24'd35);
        check_q("auto_gb", 2, 24'd34);
        check_q("auto_b", 3, 24'd33);
        v0 = nvalid;
        drive_frame(2, 4, {24'd1, 24'd1, 24'd1, 24'd1}, -1, 48'h0);
        drive_frame(2, 2, all100, -1, 48'h0);
        check("ob_short_nopulse", nvalid - v0, 0);
        check("ob_short_hold", {48'b0, ob_level}, {48'b0, 12'd67, 12'd66, 12'd65, 12'd64});
`else
        v_ofs = ofs_cfg;
        auto_en = 1'b1;
        ofs_cfg = {12'd4, 12'd3, 12'd2, 12'd1};
        outq.delete();
        drive_frame(2, 128, all100, -1, 48'h0);
        drive_frame(2, 2, all100, -1, 48'h0);
        check("noob_auto_ignored", outq.size() > 0 ? {72'b0, outq[outq.size()-4]} : 96'h0, 96'd99);
        check("noob_level", {48'b0, ob_level}, 96'h0);
        check("noob_pulses", nvalid, 0);
        ofs_cfg = v_ofs;
`endif

        chk_sync = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end
endmodule
